// File: rtl/jtdd_colmix.sv
// Colour mixer: picks the winning layer pixel, looks it up in the
// CPU-written palette and drives 4-bit RGB aligned with delayed blanking.
module jtdd_colmix #(
    parameter string       SIMFILE_RG = "pal_rg.bin",
    parameter string       SIMFILE_B  = "pal_b.bin",
    parameter int unsigned BLANK_DLY  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       cen_Q,
    input  logic [9:0] cpu_AB,
    input  logic       pal_cs,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    output logic [7:0] pal_dout,
    input  logic [6:0] char_pxl,
    input  logic [6:0] obj_pxl,
    input  logic [6:0] scr_pxl,
    input  logic       LHBL,
    input  logic       LVBL,
    output logic       LHBL_dly,
    output logic       LVBL_dly,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    // Preload file names are kept only so existing instantiations still
    // elaborate; the synthesizable palette starts with undefined contents.
    if (SIMFILE_RG == "" || SIMFILE_B == "") begin : g_no_preload
    end

    logic [7:0] ram_rg [0:511];
    logic [7:0] ram_b  [0:511];

    logic [8:0]         pal_addr;
    logic [8:0]         mux_addr;
    logic [7:0]         vid_rg;
    logic [3:0]         vid_b;
    logic [BLANK_DLY-1:0] hpipe, vpipe;
    logic [BLANK_DLY:0]   hchain, vchain;
    logic               show;
    logic               cpu_we;

    assign cpu_we = cen_Q & pal_cs & ~cpu_wrn;

    // Blank pipes with the live input at bit 0; the bit about to reach the
    // output is used to gate RGB so colour and blanking change together.
    assign hchain   = {hpipe, LHBL};
    assign vchain   = {vpipe, LVBL};
    assign LHBL_dly = hchain[BLANK_DLY];
    assign LVBL_dly = vchain[BLANK_DLY];
    assign show     = hchain[BLANK_DLY-1] & vchain[BLANK_DLY-1];

    // Layer priority: char over object over the always-opaque scroll layer
    always_comb begin
        mux_addr = {2'b10, scr_pxl};
        if (char_pxl[3:0] != 4'd0)
            mux_addr = {2'b00, char_pxl};
        else if (obj_pxl[3:0] != 4'd0)
            mux_addr = {2'b01, obj_pxl};
    end

    // CPU write port; RAM contents survive reset
    always_ff @(posedge clk) begin
        if (cpu_we) begin
            if (cpu_AB[9])
                ram_b[cpu_AB[8:0]] <= cpu_dout;
            else
                ram_rg[cpu_AB[8:0]] <= cpu_dout;
        end
    end

    // Video read port, read-before-write so a colliding CPU write is seen next read
    always_ff @(posedge clk) begin
        vid_rg <= ram_rg[pal_addr];
        vid_b  <= ram_b[pal_addr][3:0];
    end

    // CPU read port, registered every clock
    always_ff @(posedge clk) begin
        if (!rst)
            pal_dout <= '0;
        else
            pal_dout <= cpu_AB[9] ? ram_b[cpu_AB[8:0]] : ram_rg[cpu_AB[8:0]];
    end

    // Two-stage pixel pipeline and blank delay, advanced on pxl_cen
    always_ff @(posedge clk) begin
        if (!rst) begin
            pal_addr <= '0;
            hpipe    <= '0;
            vpipe    <= '0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else if (pxl_cen) begin
            pal_addr <= mux_addr;
            hpipe    <= hchain[BLANK_DLY-1:0];
            vpipe    <= vchain[BLANK_DLY-1:0];
            if (show) begin
                red   <= vid_rg[3:0];
                green <= vid_rg[7:4];
                blue  <= vid_b;
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_jtdd_colmix.sv
// Randomized self-checking bench for jtdd_colmix against a pixel-level model.
module tb_jtdd_colmix;

    logic       clk = 1'b0;
    logic       rst;
    logic       pxl_cen;
    logic       cen_Q;
    logic [9:0] cpu_AB;
    logic       pal_cs;
    logic       cpu_wrn;
    logic [7:0] cpu_dout;
    logic [7:0] pal_dout;
    logic [6:0] char_pxl, obj_pxl, scr_pxl;
    logic       LHBL, LVBL;
    logic       LHBL_dly, LVBL_dly;
    logic [3:0] red, green, blue;

    int compared   = 0;
    int mismatched = 0;

    // model state
    logic [7:0]  mem [0:1023];
    logic [8:0]  pend_addr;
    logic        pend_h, pend_v;
    logic [11:0] last_rd;
    logic [11:0] exp_rgb;
    logic        exp_h, exp_v;
    logic [7:0]  exp_dout;
    bit          chk_dout;

    always #5 clk = ~clk;

    jtdd_colmix #(.BLANK_DLY(2)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cen_Q(cen_Q),
        .cpu_AB(cpu_AB), .pal_cs(pal_cs), .cpu_wrn(cpu_wrn),
        .cpu_dout(cpu_dout), .pal_dout(pal_dout),
        .char_pxl(char_pxl), .obj_pxl(obj_pxl), .scr_pxl(scr_pxl),
        .LHBL(LHBL), .LVBL(LVBL), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
        .red(red), .green(green), .blue(blue)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] win_addr(input logic [6:0] c, input logic [6:0] o,
                                            input logic [6:0] s);
        if (c[3:0] != 0) return 9'h000 + 9'(c);
        if (o[3:0] != 0) return 9'h080 + 9'(o);
        return 9'h100 + 9'(s);
    endfunction

    function automatic logic [11:0] colour(input logic [8:0] a);
        logic [7:0] rg, b;
        rg = mem[{1'b0, a}];
        b  = mem[{1'b1, a}];
        return {rg[3:0], rg[7:4], b[3:0]};
    endfunction

    // one clock: update the model from the inputs seen at the edge, then check
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            exp_rgb = '0; exp_h = 1'b0; exp_v = 1'b0;
            pend_addr = '0; pend_h = 1'b0; pend_v = 1'b0;
            exp_dout = '0;
        end else begin
            exp_dout = mem[cpu_AB];
            if (pxl_cen) begin
                exp_rgb   = (pend_h && pend_v) ? last_rd : 12'h000;
                exp_h     = pend_h;
                exp_v     = pend_v;
                pend_addr = win_addr(char_pxl, obj_pxl, scr_pxl);
                pend_h    = LHBL;
                pend_v    = LVBL;
            end
        end
        // colour the video port sees at this clock, before this clock's write
        last_rd = colour(pend_addr);
        if (cen_Q && pal_cs && !cpu_wrn) mem[cpu_AB] = cpu_dout;
        #1;
        chk("red", red, exp_rgb[11:8]);
        chk("green", green, exp_rgb[7:4]);
        chk("blue", blue, exp_rgb[3:0]);
        chk("LHBL_dly", LHBL_dly, exp_h);
        chk("LVBL_dly", LVBL_dly, exp_v);
        if (chk_dout) chk("pal_dout", pal_dout, exp_dout);
    endtask

    task automatic cpu_wr(input logic [9:0] a, input logic [7:0] d);
        cpu_AB = a; cpu_dout = d; cen_Q = 1'b1; pal_cs = 1'b1; cpu_wrn = 1'b0;
        pxl_cen = 1'b0;
        step();
        cpu_wrn = 1'b1; pal_cs = 1'b0;
    endtask

    task automatic pix(input logic [6:0] c, input logic [6:0] o, input logic [6:0] s,
                       input logic h, input logic v);
        char_pxl = c; obj_pxl = o; scr_pxl = s; LHBL = h; LVBL = v;
        pxl_cen = 1'b1;
        step();
        pxl_cen = 1'b0;
        step();
    endtask

    task automatic rand_cpu();
        cen_Q    = ($urandom % 4) != 0;
        pal_cs   = ($urandom % 2) != 0;
        cpu_wrn  = ($urandom % 3) != 0;
        cpu_AB   = 10'($urandom);
        cpu_dout = 8'($urandom);
        if ($urandom % 4 == 0) cpu_AB = {1'($urandom), pend_addr};
    endtask

    task automatic rand_pix();
        logic [6:0] c, o;
        c = 7'($urandom);
        o = 7'($urandom);
        if ($urandom % 3 == 0) c[3:0] = 4'd0;
        if ($urandom % 3 == 0) o[3:0] = 4'd0;
        char_pxl = c;
        obj_pxl  = o;
        scr_pxl  = 7'($urandom);
        LHBL     = ($urandom % 8) != 0;
        LVBL     = ($urandom % 10) != 0;
    endtask

    initial begin
        rst = 1'b0; pxl_cen = 1'b0; cen_Q = 1'b0; pal_cs = 1'b0; cpu_wrn = 1'b1;
        cpu_AB = '0; cpu_dout = '0; LHBL = 1'b1; LVBL = 1'b1;
        char_pxl = '0; obj_pxl = '0; scr_pxl = '0;
        last_rd = '0; chk_dout = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // reset with random pixels and pixel enables
        for (int i = 0; i < 4; i++) begin
            rand_pix();
            pxl_cen = 1'($urandom);
            step();
        end
        chk("rst_red", red, 0);
        chk("rst_hbl", LHBL_dly, 0);
        chk("rst_dout", pal_dout, 0);
        rst = 1'b1;
        pxl_cen = 1'b0;

        // fill the whole palette; readback of never-written entries is undefined
        chk_dout = 1'b0;
        for (int unsigned i = 0; i < 1024; i++) cpu_wr(10'(i), 8'($urandom));
        chk_dout = 1'b1;
        cpu_wr(10'h015, 8'hA5); cpu_wr(10'h215, 8'h0C);
        cpu_wr(10'h0A3, 8'h37); cpu_wr(10'h2A3, 8'h09);
        cpu_wr(10'h131, 8'h6E); cpu_wr(10'h331, 8'h01);
        cpu_wr(10'h000, 8'h5A);

        // priority and palette path
        pix(7'h15, 7'h23, 7'h31, 1, 1);
        pix(7'h10, 7'h23, 7'h31, 1, 1);
        chk("pal015_rgb", {red, green, blue}, 12'h5AC);
        pix(7'h10, 7'h20, 7'h31, 1, 1);
        chk("prio0A3_rgb", {red, green, blue}, 12'h739);
        pix(7'h15, 7'h23, 7'h31, 1, 1);
        chk("prio131_rgb", {red, green, blue}, 12'hE61);

        // one pixel of horizontal blank
        pix(7'h15, 7'h23, 7'h31, 0, 1);
        chk("hbl_not_early", LHBL_dly, 1);
        chk("rgb_not_early", {red, green, blue}, 12'h5AC);
        pix(7'h15, 7'h23, 7'h31, 1, 1);
        chk("hbl_dly_low", LHBL_dly, 0);
        chk("rgb_blanked", {red, green, blue}, 12'h000);
        pix(7'h15, 7'h23, 7'h31, 1, 1);
        chk("hbl_dly_back", LHBL_dly, 1);
        chk("rgb_after_blank", {red, green, blue}, 12'h5AC);

        // CPU write hitting the entry being displayed
        char_pxl = 7'h15; pxl_cen = 1'b1;
        step();
        cpu_wr(10'h015, 8'h99);
        pxl_cen = 1'b1;
        step();
        chk("collide_old", {red, green}, 8'h5A);
        pxl_cen = 1'b0;
        step();
        pxl_cen = 1'b1;
        step();
        chk("collide_new", {red, green}, 8'h99);
        pxl_cen = 1'b0;

        // CPU readback
        cpu_wr(10'h200, 8'h3C);
        cpu_AB = 10'h200;
        step();
        chk("readback_200", pal_dout, 8'h3C);
        cpu_AB = 10'h000;
        step();
        chk("readback_000", pal_dout, 8'h5A);

        // random traffic with uneven pixel spacing and a mid-line reset
        for (int n = 0; n < 300; n++) begin
            if (n == 150) begin
                cpu_wrn = 1'b1;
                rst = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    rand_pix();
                    pxl_cen = 1'($urandom);
                    step();
                end
                rst = 1'b1;
            end
            rand_pix();
            rand_cpu();
            pxl_cen = 1'b1;
            step();
            pxl_cen = 1'b0;
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                rand_cpu();
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
